// File: rtl/knot_key_provisioner.sv
//------------------------------------------------------------------------------
// knot_key_provisioner
//
// Key-delivery front end for a logic-locked controller FSM. A key arrives
// serially (LSB first) over a valid/ready handshake, is collected in a shadow
// register, optionally parity-checked, and then presented on o_keyinput. The
// locked FSM is held in reset (o_fsm_rst=1) until a checked key is in place.
// Failed attempts (bad parity or an idle timeout while loading) are counted,
// and a sticky fault is raised once the retry budget is used up.
//
// Optional feature macro: KNOT_KEY_PARITY_EN
//   defined   : one even-parity bit follows the data bits and is checked.
//   undefined : no parity bit; only load timeouts count as failures.
//
// Parameters:
//   KEY_WIDTH  number of key bits delivered to the locked FSM
//   MAX_RETRY  failed attempts allowed before FAULT (1..15)
//   TIMEOUT    idle cycles allowed in LOAD before the attempt fails (1..65535)
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-low reset
//   i_start      request to begin a key load (honoured only in IDLE)
//   i_zeroize    synchronous key wipe
//   i_key_valid  source presents i_key_bit
//   i_key_bit    serial key data (then parity bit when enabled)
//   o_key_ready  block accepts a bit this cycle (registered state decode)
//   o_keyinput   key to the locked FSM
//   o_key_armed  o_keyinput holds a checked key
//   o_fsm_rst    active-high reset for the locked FSM
//   o_fault      sticky, retry budget exhausted
//------------------------------------------------------------------------------
module knot_key_provisioner #(
  parameter int KEY_WIDTH = 8,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_zeroize,
  input  logic                 i_key_valid,
  input  logic                 i_key_bit,
  output logic                 o_key_ready,
  output logic [KEY_WIDTH-1:0] o_keyinput,
  output logic                 o_key_armed,
  output logic                 o_fsm_rst,
  output logic                 o_fault
);

  localparam int CNT_W = $clog2(KEY_WIDTH + 1);

  // Index of the final bit of an attempt: the parity bit when enabled,
  // otherwise the most significant data bit.
`ifdef KNOT_KEY_PARITY_EN
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH);
`else
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);
  // The timeout counter counts completed idle cycles; the attempt fails on
  // the idle edge that would bring it to TIMEOUT.
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ARMED = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

`ifdef KNOT_KEY_PARITY_EN
  // Even parity over the data bits: XOR of all bits.
  function automatic logic f_even_parity(input logic [KEY_WIDTH-1:0] d);
    f_even_parity = ^d;
  endfunction
`endif

  state_t                 r_state;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [KEY_WIDTH-1:0]   r_shadow;
  logic [3:0]             r_retry_cnt;
  logic [15:0]            r_timeout_cnt;
  logic [KEY_WIDTH-1:0]   r_keyinput;
  logic                   r_key_ready;
  logic                   r_key_armed;
  logic                   r_fsm_rst;
  logic                   r_fault;
`ifdef KNOT_KEY_PARITY_EN
  logic                   r_par_bit;
  logic                   w_par_next;
`endif

  state_t                 w_state_next;
  logic [CNT_W-1:0]       w_bit_cnt_next;
  logic [KEY_WIDTH-1:0]   w_shadow_next;
  logic [3:0]             w_retry_next;
  logic [3:0]             w_retry_inc;
  logic [15:0]            w_timeout_next;
  logic [KEY_WIDTH-1:0]   w_keyinput_next;
  logic                   w_accept;
  logic                   w_pass;
  logic                   w_fail;

  // Next-state, datapath and failure handling; zeroize is applied last so it
  // overrides everything except the FAULT state itself.
  always_comb begin
    w_state_next    = r_state;
    w_bit_cnt_next  = r_bit_cnt;
    w_shadow_next   = r_shadow;
    w_retry_next    = r_retry_cnt;
    w_timeout_next  = r_timeout_cnt;
    w_keyinput_next = r_keyinput;
    w_fail          = 1'b0;
    w_accept        = r_key_ready & i_key_valid & (r_state == ST_LOAD);
    w_retry_inc     = (r_retry_cnt == 4'hF) ? r_retry_cnt : (r_retry_cnt + 4'd1);
`ifdef KNOT_KEY_PARITY_EN
    w_par_next      = r_par_bit;
    w_pass          = (f_even_parity(r_shadow) == r_par_bit);
`else
    w_pass          = 1'b1;
`endif

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next   = ST_LOAD;
          w_bit_cnt_next = CNT_ZERO;
          w_timeout_next = 16'd0;
          w_shadow_next  = '0;
`ifdef KNOT_KEY_PARITY_EN
          w_par_next     = 1'b0;
`endif
        end else begin
          w_state_next   = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          w_timeout_next = 16'd0;
          // Bit counter value selects the shadow bit; values >= KEY_WIDTH
          // (the parity slot) leave the shadow untouched.
          for (int i = 0; i < KEY_WIDTH; i++) begin
            w_shadow_next[i] = (r_bit_cnt == CNT_W'(i)) ? i_key_bit : r_shadow[i];
          end
`ifdef KNOT_KEY_PARITY_EN
          if (r_bit_cnt == LAST_BIT) begin
            w_par_next = i_key_bit;
          end else begin
            w_par_next = r_par_bit;
          end
`endif
          if (r_bit_cnt == LAST_BIT) begin
            w_state_next = ST_CHECK;
          end else begin
            w_bit_cnt_next = r_bit_cnt + CNT_ONE;
          end
        end else begin
          if (r_timeout_cnt >= TO_LAST) begin
            w_fail = 1'b1;
          end else begin
            w_timeout_next = (r_timeout_cnt == 16'hFFFF) ? r_timeout_cnt
                                                          : (r_timeout_cnt + 16'd1);
          end
        end
      end

      ST_CHECK: begin
        if (w_pass) begin
          w_keyinput_next = r_shadow;
          w_state_next    = ST_ARMED;
        end else begin
          w_fail = 1'b1;
        end
      end

      ST_ARMED: begin
        w_state_next = ST_ARMED;
      end

      ST_FAULT: begin
        w_state_next = ST_FAULT;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // A failed attempt (bad check or timeout): charge one retry and either
    // give up or restart the load from a clean shadow.
    if (w_fail) begin
      w_retry_next = w_retry_inc;
      if (w_retry_inc == RETRY_LIMIT) begin
        w_state_next = ST_FAULT;
      end else begin
        w_state_next   = ST_LOAD;
        w_bit_cnt_next = CNT_ZERO;
        w_shadow_next  = '0;
        w_timeout_next = 16'd0;
`ifdef KNOT_KEY_PARITY_EN
        w_par_next     = 1'b0;
`endif
      end
    end else begin
      w_retry_next = r_retry_cnt;
    end

    // Zeroize wipes key material everywhere; only FAULT keeps its state.
    if (i_zeroize) begin
      w_keyinput_next = '0;
      w_shadow_next   = '0;
      if (r_state != ST_FAULT) begin
        w_state_next = ST_IDLE;
      end else begin
        w_state_next = ST_FAULT;
      end
    end else begin
      w_keyinput_next = w_keyinput_next;
    end
  end

  // State and datapath registers; outputs are registered decodes of the
  // next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= CNT_ZERO;
      r_shadow      <= '0;
      r_retry_cnt   <= 4'd0;
      r_timeout_cnt <= 16'd0;
      r_keyinput    <= '0;
      r_key_ready   <= 1'b0;
      r_key_armed   <= 1'b0;
      r_fsm_rst     <= 1'b1;
      r_fault       <= 1'b0;
`ifdef KNOT_KEY_PARITY_EN
      r_par_bit     <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_shadow      <= w_shadow_next;
      r_retry_cnt   <= w_retry_next;
      r_timeout_cnt <= w_timeout_next;
      r_keyinput    <= w_keyinput_next;
      r_key_ready   <= (w_state_next == ST_LOAD);
      r_key_armed   <= (w_state_next == ST_ARMED);
      // Release the locked FSM one edge after ARMED is entered, and pull it
      // back into reset on the same edge that leaves ARMED.
      r_fsm_rst     <= ~((r_state == ST_ARMED) && (w_state_next == ST_ARMED));
      r_fault       <= (w_state_next == ST_FAULT);
`ifdef KNOT_KEY_PARITY_EN
      r_par_bit     <= w_par_next;
`endif
    end
  end

  assign o_key_ready = r_key_ready;
  assign o_keyinput  = r_keyinput;
  assign o_key_armed = r_key_armed;
  assign o_fsm_rst   = r_fsm_rst;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_knot_key_provisioner.sv
module tb_knot_key_provisioner;

  localparam int KW = 8;
`ifdef KNOT_KEY_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = KW + PAR;

  logic          clk;
  logic          rst;
  logic          start;
  logic          zeroize;
  logic          key_valid;
  logic          key_bit;
  logic          key_ready;
  logic [KW-1:0] keyinput;
  logic          key_armed;
  logic          fsm_rst;
  logic          fault;

  int n_cmp = 0;
  int n_bad = 0;

  knot_key_provisioner #(.KEY_WIDTH(8), .MAX_RETRY(3), .TIMEOUT(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_zeroize   (zeroize),
    .i_key_valid (key_valid),
    .i_key_bit   (key_bit),
    .o_key_ready (key_ready),
    .o_keyinput  (keyinput),
    .o_key_armed (key_armed),
    .o_fsm_rst   (fsm_rst),
    .o_fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_zeroize();
    zeroize = 1'b1; tick(); zeroize = 1'b0;
  endtask

  // Sends the data bits LSB first, then the parity bit when enabled.
  task automatic send_key(input logic [7:0] k, input logic p);
    for (int i = 0; i < KW; i++) begin
      key_valid = 1'b1; key_bit = k[i]; tick();
    end
    if (PAR == 1) begin
      key_valid = 1'b1; key_bit = p; tick();
    end
    key_valid = 1'b0; key_bit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick();
    rst = 1'b1; tick();
    n_cmp++; if (keyinput !== 8'h00) begin n_bad++; $display("FAIL reset_keyinput: got %h want 00", keyinput); end
    n_cmp++; if (fsm_rst !== 1'b1) begin n_bad++; $display("FAIL reset_fsm_rst: got %b want 1", fsm_rst); end
    n_cmp++; if (key_armed !== 1'b0) begin n_bad++; $display("FAIL reset_armed: got %b want 0", key_armed); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", key_ready); end
  endtask

  task automatic test_good_load();
    logic [7:0] k;
    k = 8'hA5;
    pulse_start();
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL good_ready_after_start: got %b want 1", key_ready); end
    send_key(k, 1'b0);           // now just after E0
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL good_ready_E0: got %b want 0", key_ready); end
    n_cmp++; if (key_armed !== 1'b0) begin n_bad++; $display("FAIL good_armed_E0: got %b want 0", key_armed); end
    tick();                      // E1
    n_cmp++; if (keyinput !== 8'hA5) begin n_bad++; $display("FAIL good_keyinput_E1: got %h want a5", keyinput); end
    n_cmp++; if (key_armed !== 1'b1) begin n_bad++; $display("FAIL good_armed_E1: got %b want 1", key_armed); end
    n_cmp++; if (fsm_rst !== 1'b1) begin n_bad++; $display("FAIL good_fsm_rst_E1: got %b want 1", fsm_rst); end
    tick();                      // E2
    n_cmp++; if (fsm_rst !== 1'b0) begin n_bad++; $display("FAIL good_fsm_rst_E2: got %b want 0", fsm_rst); end
    // Key must hold while armed, even with traffic and start on the inputs.
    start = 1'b1; key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin key_bit = i[0]; tick(); end
    start = 1'b0; key_valid = 1'b0;
    n_cmp++; if (keyinput !== 8'hA5) begin n_bad++; $display("FAIL armed_hold_keyinput: got %h want a5", keyinput); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL armed_hold_ready: got %b want 0", key_ready); end
    pulse_zeroize();
    n_cmp++; if (keyinput !== 8'h00) begin n_bad++; $display("FAIL good_zeroize_keyinput: got %h want 00", keyinput); end
    n_cmp++; if (fsm_rst !== 1'b1) begin n_bad++; $display("FAIL good_zeroize_fsm_rst: got %b want 1", fsm_rst); end
  endtask

  task automatic test_backpressure();
    logic [7:0] k;
    logic       nxt;
    int         sent;
    k = 8'hA5; sent = 0;
    pulse_start();
    for (int c = 0; c < 2 * NB; c++) begin
      nxt = (sent < KW) ? k[sent] : 1'b0;
      if ((c % 2) == 0) begin
        key_valid = 1'b1; key_bit = nxt; sent++;
      end else begin
        key_valid = 1'b0; key_bit = ~nxt;   // wrong data on idle cycles
      end
      tick();
      if (sent == NB - 1 && (c % 2) == 0) begin
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_before_last: got %b want 1", key_ready); end
      end
    end
    key_valid = 1'b0; key_bit = 1'b0;
    // Final accept was on the previous edge; this edge resolved CHECK.
    n_cmp++; if (keyinput !== 8'hA5) begin n_bad++; $display("FAIL bp_keyinput: got %h want a5", keyinput); end
    n_cmp++; if (key_armed !== 1'b1) begin n_bad++; $display("FAIL bp_armed: got %b want 1", key_armed); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_done: got %b want 0", key_ready); end
    tick();
    n_cmp++; if (fsm_rst !== 1'b0) begin n_bad++; $display("FAIL bp_fsm_rst: got %b want 0", fsm_rst); end
    pulse_zeroize();
  endtask

  task automatic test_zeroize();
    pulse_start();
    send_key(8'h3C, 1'b0);
    tick(); tick();
    n_cmp++; if (keyinput !== 8'h3C) begin n_bad++; $display("FAIL zero_pre_keyinput: got %h want 3c", keyinput); end
    n_cmp++; if (fsm_rst !== 1'b0) begin n_bad++; $display("FAIL zero_pre_fsm_rst: got %b want 0", fsm_rst); end
    zeroize = 1'b1; start = 1'b1; tick(); zeroize = 1'b0; start = 1'b0;
    n_cmp++; if (keyinput !== 8'h00) begin n_bad++; $display("FAIL zero_keyinput: got %h want 00", keyinput); end
    n_cmp++; if (key_armed !== 1'b0) begin n_bad++; $display("FAIL zero_armed: got %b want 0", key_armed); end
    n_cmp++; if (fsm_rst !== 1'b1) begin n_bad++; $display("FAIL zero_fsm_rst: got %b want 1", fsm_rst); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_idle: got %b want 0", key_ready); end
    // Still in IDLE: a fresh start is honoured.
    pulse_start();
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL zero_restart_ready: got %b want 1", key_ready); end
    pulse_zeroize();
  endtask

  task automatic test_timeout();
    pulse_start();
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready_15: got %b want 1", key_ready); end
    tick();  // 16th idle edge: attempt fails, back to LOAD
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready_16: got %b want 1", key_ready); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL to_fault_1: got %b want 0", fault); end
    // Bit counter restarted at 0: a full key loads cleanly.
    send_key(8'h5A, 1'b0);
    tick();
    n_cmp++; if (keyinput !== 8'h5A) begin n_bad++; $display("FAIL to_reload_keyinput: got %h want 5a", keyinput); end
    n_cmp++; if (key_armed !== 1'b1) begin n_bad++; $display("FAIL to_reload_armed: got %b want 1", key_armed); end
    // Zeroize keeps the retry count (1): two more timeouts reach FAULT.
    pulse_zeroize();
    pulse_start();
    for (int i = 0; i < 16; i++) tick();
    n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL to_ready_2nd: got %b want 1", key_ready); end
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL to_fault_early: got %b want 0", fault); end
    tick();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL to_fault_3rd: got %b want 1", fault); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL to_ready_fault: got %b want 0", key_ready); end
    rst = 1'b0; tick(); rst = 1'b1;
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL to_rst_fault: got %b want 0", fault); end
  endtask

  task automatic test_retry_exhaustion();
`ifdef KNOT_KEY_PARITY_EN
    pulse_start();
    for (int a = 1; a <= 3; a++) begin
      send_key(8'hA5, 1'b1);
      tick();  // CHECK resolves
      if (a < 3) begin
        n_cmp++; if (key_ready !== 1'b1) begin n_bad++; $display("FAIL retry_ready_att%0d: got %b want 1", a, key_ready); end
        n_cmp++; if (key_armed !== 1'b0) begin n_bad++; $display("FAIL retry_armed_att%0d: got %b want 0", a, key_armed); end
        n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL retry_fault_att%0d: got %b want 0", a, fault); end
      end
    end
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL retry_fault: got %b want 1", fault); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL retry_ready: got %b want 0", key_ready); end
    n_cmp++; if (fsm_rst !== 1'b1) begin n_bad++; $display("FAIL retry_fsm_rst: got %b want 1", fsm_rst); end
    n_cmp++; if (keyinput !== 8'h00) begin n_bad++; $display("FAIL retry_keyinput: got %h want 00", keyinput); end
    pulse_zeroize();
    pulse_start();
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL retry_zeroize_fault: got %b want 1", fault); end
    n_cmp++; if (key_ready !== 1'b0) begin n_bad++; $display("FAIL retry_zeroize_ready: got %b want 0", key_ready); end
`else
    // Without parity, CHECK always passes: an odd-weight key arms.
    pulse_start();
    send_key(8'h01, 1'b0);
    tick();
    n_cmp++; if (key_armed !== 1'b1) begin n_bad++; $display("FAIL nopar_armed: got %b want 1", key_armed); end
    n_cmp++; if (keyinput !== 8'h01) begin n_bad++; $display("FAIL nopar_keyinput: got %h want 01", keyinput); end
`endif
    rst = 1'b0; tick(); rst = 1'b1;
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL retry_rst_fault: got %b want 0", fault); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; zeroize = 1'b0; key_valid = 1'b0; key_bit = 1'b0;
    test_reset();
    test_good_load();
    test_backpressure();
    test_zeroize();
    test_timeout();
    test_retry_exhaustion();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
